regfile_llsc: RTL and testbench
===============================

Name: regfile_llsc

Overview:
- Parametrised general-purpose register file: two combinational read ports, one synchronous write port.
- Adds four things to the basic register file:
  - optional hardwired-zero register 0;
  - optional write-to-read bypass;
  - full synchronous reset of the array;
  - a real LL/SC reservation unit (link bit plus reservation address, with set, clear, consume and store-snoop invalidate).
- Sits in the decode stage. The SC success flag feeds the memory stage and the writeback of the SC result.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- RES_ADDR_W, 32, byte-address width for LL/SC reservation.
- GRAN_LSB, 2, low address bits ignored in reservation compare (2 = word granule).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port.

Ports:
- Clk, input, 1, clock; all state updates on rising edge.
- Reset, input, 1, synchronous active-high reset.
- Read1, input, ADDR_W, read port 1 index.
- Read2, input, ADDR_W, read port 2 index.
- Data1, output, DATA_W, read port 1 data (combinational).
- Data2, output, DATA_W, read port 2 data (combinational).
- WriteReg, input, ADDR_W, write index.
- WriteData, input, DATA_W, write data.
- RegWrite, input, 1, write enable.
- LLSet, input, 1, LL executing; open reservation at LLAddr.
- LLAddr, input, RES_ADDR_W, LL byte address.
- SCCheck, input, 1, SC executing; consume reservation.
- SCAddr, input, RES_ADDR_W, SC byte address.
- SCSuccess, output, 1, SC will succeed (combinational).
- StoreSnoop, input, 1, a store (own or external) is committing.
- StoreAddr, input, RES_ADDR_W, snooped store byte address.
- LLClear, input, 1, exception return / context switch; drop reservation.
- LLbitout, output, 1, current link bit (registered).
- ResAddr, output, RES_ADDR_W, current reservation address (registered; debug / CP0 LLAddr).

Behaviour:
- Reset (sync, active-high, Clk edge with Reset=1):
  - all 2**ADDR_W registers <= 0;
  - LLbitout <= 0, ResAddr <= 0.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-reservation drops the reservation.
- Write:
  - On rising Clk, if RegWrite and not Reset: RF[WriteReg] <= WriteData.
  - With ZERO_REG=1, writes to index 0 are discarded.
- Read: combinational, with per-port priority:
  1. ZERO_REG=1 and index==0 -> 0.
  2. BYPASS=1, RegWrite=1 and index==WriteReg -> WriteData.
  3. Otherwise RF[index].
  - With BYPASS=0, a same-cycle write is visible only after the edge.
  - Both ports may read the same index; both return identical data.
- Granule match: match(a,b) = (a[RES_ADDR_W-1:GRAN_LSB] == b[RES_ADDR_W-1:GRAN_LSB]).
- SCSuccess = SCCheck & LLbitout & match(SCAddr, ResAddr).
  - Depends only on current registered state, not on same-cycle LLSet, LLClear or StoreSnoop.
- Link-bit / reservation update, evaluated each rising edge in priority order:
  1. Reset -> LLbitout <= 0, ResAddr <= 0.
  2. LLClear -> LLbitout <= 0; ResAddr held.
  3. LLSet -> LLbitout <= 1, ResAddr <= LLAddr. A fresh reservation wins over a same-cycle SCCheck or StoreSnoop.
  4. SCCheck -> LLbitout <= 0, whether the SC succeeds or fails.
  5. StoreSnoop & match(StoreAddr, ResAddr) -> LLbitout <= 0.
  6. Otherwise hold.
- Latency:
  - Link-bit changes are visible on LLbitout and in SCSuccess one cycle after the causing edge.
  - A second SC in the cycle immediately after a successful SC fails.
- Independence: the register array and the reservation unit do not interact. An SC result write is an ordinary RegWrite driven by the pipeline from SCSuccess.
- No X propagation: every output is defined from the first cycle after reset.

Test Plan:
1. Reset, then read indices 0..31 on both ports -> all 0; LLbitout=0; ResAddr=0; SCSuccess=0 with SCCheck=1.
2. Write 0xDEADBEEF to r5; next cycle Read1=Read2=5 -> both 0xDEADBEEF.
   - Write 0x12345678 to r0 -> Read1=0 returns 0.
   - BYPASS=1: Read1=7 while RegWrite=1, WriteReg=7, WriteData=0xA5A5A5A5 -> Data1=0xA5A5A5A5 in the same cycle.
3. LLSet with LLAddr=0x1000; next cycle SCCheck with SCAddr=0x1002 -> SCSuccess=1; following cycle LLbitout=0; repeat SC -> SCSuccess=0.
4. LLSet at 0x2000; then StoreSnoop at 0x2004 -> LLbitout stays 1. Then StoreSnoop at 0x2001 -> LLbitout=0 next cycle; SC at 0x2000 -> SCSuccess=0.
5. Simultaneous events:
   - LLSet(0x3000), SCCheck and StoreSnoop(0x3000) in one cycle -> LLbitout=1, ResAddr=0x3000.
   - LLClear with LLSet in the same cycle -> LLbitout=0.
6. Mid-operation reset: LLSet at 0x4000, write r9=0xFFFF0000, then Reset for 1 cycle -> LLbitout=0, r9 reads 0, SC at 0x4000 fails.

Source files
------------

// File: rtl/regfile_llsc.sv
// Decode-stage register file: two combinational read ports, one synchronous write port,
// optional hardwired zero / write bypass, plus an LL/SC reservation unit.
module regfile_llsc #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int RES_ADDR_W = 32,
  parameter int GRAN_LSB   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_W-1:0]     Read1,
  input  logic [ADDR_W-1:0]     Read2,
  output logic [DATA_W-1:0]     Data1,
  output logic [DATA_W-1:0]     Data2,
  input  logic [ADDR_W-1:0]     WriteReg,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic                  RegWrite,
  input  logic                  LLSet,
  input  logic [RES_ADDR_W-1:0] LLAddr,
  input  logic                  SCCheck,
  input  logic [RES_ADDR_W-1:0] SCAddr,
  output logic                  SCSuccess,
  input  logic                  StoreSnoop,
  input  logic [RES_ADDR_W-1:0] StoreAddr,
  input  logic                  LLClear,
  output logic                  LLbitout,
  output logic [RES_ADDR_W-1:0] ResAddr
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Bits below the granule are masked out rather than sliced so every address bit is consumed.
  localparam logic [RES_ADDR_W-1:0] GRAN_MASK = {RES_ADDR_W{1'b1}} << GRAN_LSB;

  logic [DATA_W-1:0]     rf_r [DEPTH];
  logic                  llbit_r;
  logic [RES_ADDR_W-1:0] res_addr_r;
  logic [DATA_W-1:0]     data1_s;
  logic [DATA_W-1:0]     data2_s;
  logic                  wr_en_s;

  function automatic logic gran_match(input logic [RES_ADDR_W-1:0] a,
                                      input logic [RES_ADDR_W-1:0] b);
    return ((a ^ b) & GRAN_MASK) == {RES_ADDR_W{1'b0}};
  endfunction

  // Write qualification: index 0 is read-only when hardwired to zero.
  always_comb begin
    wr_en_s = 1'b0;
    if (ZERO_REG && (WriteReg == {ADDR_W{1'b0}})) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = RegWrite;
    end
  end

  // Register array: full clear on reset, otherwise single write port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      rf_r[WriteReg] <= WriteData;
    end
  end

  // Read port 1: zero register, then bypass, then array.
  always_comb begin
    data1_s = {DATA_W{1'b0}};
    if (ZERO_REG && (Read1 == {ADDR_W{1'b0}})) begin
      data1_s = {DATA_W{1'b0}};
    end else if (BYPASS && RegWrite && (Read1 == WriteReg)) begin
      data1_s = WriteData;
    end else begin
      data1_s = rf_r[Read1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    data2_s = {DATA_W{1'b0}};
    if (ZERO_REG && (Read2 == {ADDR_W{1'b0}})) begin
      data2_s = {DATA_W{1'b0}};
    end else if (BYPASS && RegWrite && (Read2 == WriteReg)) begin
      data2_s = WriteData;
    end else begin
      data2_s = rf_r[Read2];
    end
  end

  assign Data1 = data1_s;
  assign Data2 = data2_s;

  // Reservation unit: a new LL outranks a same-cycle SC or snoop; LLClear outranks the LL.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      llbit_r    <= 1'b0;
      res_addr_r <= {RES_ADDR_W{1'b0}};
    end else if (LLClear) begin
      llbit_r    <= 1'b0;
    end else if (LLSet) begin
      llbit_r    <= 1'b1;
      res_addr_r <= LLAddr;
    end else if (SCCheck) begin
      llbit_r    <= 1'b0;
    end else if (StoreSnoop && gran_match(StoreAddr, res_addr_r)) begin
      llbit_r    <= 1'b0;
    end
  end

  // SC outcome looks only at registered state, never at same-cycle reservation traffic.
  assign SCSuccess = SCCheck & llbit_r & gran_match(SCAddr, res_addr_r);
  assign LLbitout  = llbit_r;
  assign ResAddr   = res_addr_r;

endmodule

// File: tb/tb_regfile_llsc.sv
// Directed bench for regfile_llsc: stimulus queues expected outputs, a negedge monitor
// pops and compares them in the cycle they were issued for.
module tb_regfile_llsc;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  Read1, Read2, WriteReg;
  logic [31:0] Data1, Data2, WriteData;
  logic        RegWrite, LLSet, SCCheck, StoreSnoop, LLClear;
  logic [31:0] LLAddr, SCAddr, StoreAddr, ResAddr;
  logic        SCSuccess, LLbitout;

  regfile_llsc dut (
    .Clk(Clk), .Reset(Reset), .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .LLSet(LLSet), .LLAddr(LLAddr), .SCCheck(SCCheck), .SCAddr(SCAddr), .SCSuccess(SCSuccess),
    .StoreSnoop(StoreSnoop), .StoreAddr(StoreAddr), .LLClear(LLClear),
    .LLbitout(LLbitout), .ResAddr(ResAddr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  localparam int S_D1 = 0, S_D2 = 1, S_SC = 2, S_LL = 3, S_RA = 4;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: compare every expectation belonging to the current cycle.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_D1:    act = Data1;
        S_D2:    act = Data2;
        S_SC:    act = {31'd0, SCSuccess};
        S_LL:    act = {31'd0, LLbitout};
        S_RA:    act = ResAddr;
        default: act = 32'hxxxxxxxx;
      endcase
      checks++;
      if (act !== e.val || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h, want %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; RegWrite = 1'b0; LLSet = 1'b0; SCCheck = 1'b0;
    StoreSnoop = 1'b0; LLClear = 1'b0;
    WriteReg = 5'd0; WriteData = 32'd0; LLAddr = 32'd0; SCAddr = 32'd0; StoreAddr = 32'd0;
    Read1 = 5'd0; Read2 = 5'd0;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    step();
    // 1: reset state
    idle();
    SCCheck = 1'b1; SCAddr = 32'd0;
    expect_out(S_SC, 32'd0, "reset_sc");
    expect_out(S_LL, 32'd0, "reset_llbit");
    expect_out(S_RA, 32'd0, "reset_resaddr");
    for (int i = 0; i < 32; i++) begin
      step();
      idle();
      Read1 = 5'(i); Read2 = 5'(31 - i);
      expect_out(S_D1, 32'd0, $sformatf("reset_rd1_r%0d", i));
      expect_out(S_D2, 32'd0, $sformatf("reset_rd2_r%0d", 31 - i));
    end
    // 2: write / zero register / bypass
    step(); idle();
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    step(); idle();
    Read1 = 5'd5; Read2 = 5'd5;
    expect_out(S_D1, 32'hDEADBEEF, "wr_r5_p1");
    expect_out(S_D2, 32'hDEADBEEF, "wr_r5_p2");
    step(); idle();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; Read1 = 5'd0;
    expect_out(S_D1, 32'd0, "r0_no_bypass");
    step(); idle();
    Read1 = 5'd0; Read2 = 5'd0;
    expect_out(S_D1, 32'd0, "r0_after_write");
    step(); idle();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5; Read1 = 5'd7; Read2 = 5'd5;
    expect_out(S_D1, 32'hA5A5A5A5, "bypass_r7");
    expect_out(S_D2, 32'hDEADBEEF, "nobypass_r5");
    step(); idle();
    Read1 = 5'd7;
    expect_out(S_D1, 32'hA5A5A5A5, "r7_stored");
    // 3: LL / SC success, then second SC fails
    step(); idle();
    LLSet = 1'b1; LLAddr = 32'h1000;
    expect_out(S_LL, 32'd0, "ll_latency");
    step(); idle();
    SCCheck = 1'b1; SCAddr = 32'h1002;
    expect_out(S_SC, 32'd1, "sc_success");
    expect_out(S_LL, 32'd1, "ll_set");
    expect_out(S_RA, 32'h1000, "resaddr_1000");
    step(); idle();
    SCCheck = 1'b1; SCAddr = 32'h1002;
    expect_out(S_LL, 32'd0, "sc_consumed");
    expect_out(S_SC, 32'd0, "sc_repeat_fail");
    // 4: store snoop granularity
    step(); idle();
    LLSet = 1'b1; LLAddr = 32'h2000;
    step(); idle();
    StoreSnoop = 1'b1; StoreAddr = 32'h2004;
    expect_out(S_LL, 32'd1, "ll_2000");
    expect_out(S_RA, 32'h2000, "resaddr_2000");
    step(); idle();
    StoreSnoop = 1'b1; StoreAddr = 32'h2001;
    SCCheck = 1'b0; SCAddr = 32'h2004;
    expect_out(S_LL, 32'd1, "snoop_other_word");
    step(); idle();
    SCCheck = 1'b1; SCAddr = 32'h2000;
    expect_out(S_LL, 32'd0, "snoop_same_word");
    expect_out(S_SC, 32'd0, "sc_after_snoop");
    step(); idle();
    LLSet = 1'b1; LLAddr = 32'h2000;
    step(); idle();
    SCCheck = 1'b1; SCAddr = 32'h2004;
    expect_out(S_SC, 32'd0, "sc_wrong_granule");
    // 5: simultaneous events
    step(); idle();
    LLSet = 1'b1; LLAddr = 32'h3000; SCCheck = 1'b1; SCAddr = 32'h3000;
    StoreSnoop = 1'b1; StoreAddr = 32'h3000;
    expect_out(S_SC, 32'd0, "sc_ignores_same_cycle_ll");
    step(); idle();
    expect_out(S_LL, 32'd1, "ll_beats_sc_snoop");
    expect_out(S_RA, 32'h3000, "resaddr_3000");
    step(); idle();
    LLClear = 1'b1; LLSet = 1'b1; LLAddr = 32'h5000;
    step(); idle();
    SCCheck = 1'b1; SCAddr = 32'h3000;
    expect_out(S_LL, 32'd0, "clear_beats_ll");
    expect_out(S_RA, 32'h3000, "clear_holds_resaddr");
    expect_out(S_SC, 32'd0, "sc_after_clear");
    // 6: reset mid-reservation
    step(); idle();
    LLSet = 1'b1; LLAddr = 32'h4000;
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hFFFF0000;
    step(); idle();
    Read1 = 5'd9;
    expect_out(S_D1, 32'hFFFF0000, "r9_written");
    expect_out(S_LL, 32'd1, "ll_4000");
    step(); idle();
    Reset = 1'b1;
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h00000011;
    LLSet = 1'b1; LLAddr = 32'h6000;
    step(); idle();
    Read1 = 5'd9; Read2 = 5'd3;
    SCCheck = 1'b1; SCAddr = 32'h4000;
    expect_out(S_D1, 32'd0, "r9_after_reset");
    expect_out(S_D2, 32'd0, "reset_beats_write");
    expect_out(S_LL, 32'd0, "reset_drops_ll");
    expect_out(S_RA, 32'd0, "reset_resaddr_mid");
    expect_out(S_SC, 32'd0, "sc_after_reset");
    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    idle();
    if (sb.size() > 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
